// File: rtl/shreg_univ_al_seq.sv
// Universal shift register with eight manual modes and a built-in WIDTH-cycle serializer.
// Optional feature macro: SHREG_UNIV_PARITY_EN adds parity_out, the XOR of bits received per transfer.
module shreg_univ_al_seq #(
  parameter int               WIDTH     = 8,
  parameter bit               LSB_FIRST = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_al_in,
  input  logic             en_in,
  input  logic [2:0]       mode_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ser_in,
  input  logic             start_in,
  output logic [WIDTH-1:0] q_out,
  output logic             ser_out,
  output logic             busy_out,
  output logic             done_out
`ifdef SHREG_UNIV_PARITY_EN
  ,
  output logic             parity_out
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHL   = 3'b010,
    MODE_SHR   = 3'b011,
    MODE_ROTL  = 3'b100,
    MODE_ROTR  = 3'b101,
    MODE_SET   = 3'b110,
    MODE_CLR   = 3'b111
  } mode_e;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] ser_shift;
  logic             busy_nxt;
  logic             done_nxt;
  logic             last_bit;

  assign ser_out   = LSB_FIRST ? q_out[0] : q_out[WIDTH-1];
  // The serializer always moves data toward the ser_out end and refills from ser_in.
  assign ser_shift = LSB_FIRST ? {ser_in, q_out[WIDTH-1:1]} : {q_out[WIDTH-2:0], ser_in};
  assign last_bit  = busy_out && (cnt == LAST);

  always_comb begin
    q_nxt    = q_out;
    busy_nxt = busy_out;
    done_nxt = 1'b0;
    cnt_nxt  = cnt;
    if (busy_out) begin
      q_nxt = ser_shift;
      if (cnt == LAST) begin
        busy_nxt = 1'b0;
        done_nxt = 1'b1;
        cnt_nxt  = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end else if (start_in) begin
      q_nxt    = d_in;
      busy_nxt = 1'b1;
      cnt_nxt  = '0;
    end else begin
      case (mode_e'(mode_in))
        MODE_HOLD: q_nxt = q_out;
        MODE_LOAD: q_nxt = d_in;
        MODE_SHL:  q_nxt = {q_out[WIDTH-2:0], ser_in};
        MODE_SHR:  q_nxt = {ser_in, q_out[WIDTH-1:1]};
        MODE_ROTL: q_nxt = {q_out[WIDTH-2:0], q_out[WIDTH-1]};
        MODE_ROTR: q_nxt = {q_out[0], q_out[WIDTH-1:1]};
        MODE_SET:  q_nxt = '1;
        MODE_CLR:  q_nxt = '0;
        default:   q_nxt = q_out;
      endcase
    end
  end

  // A disabled edge freezes everything but still retires a pending done pulse.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      q_out    <= RESET_VAL;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      cnt      <= '0;
    end else if (en_in) begin
      q_out    <= q_nxt;
      busy_out <= busy_nxt;
      done_out <= done_nxt;
      cnt      <= cnt_nxt;
    end else begin
      done_out <= 1'b0;
    end
  end

`ifdef SHREG_UNIV_PARITY_EN
  logic parity_acc;

  // parity_out is published on the completion edge and then held until the next one.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      parity_acc <= 1'b0;
      parity_out <= 1'b0;
    end else if (en_in) begin
      if (busy_out) begin
        parity_acc <= last_bit ? 1'b0 : (parity_acc ^ ser_in);
        if (last_bit) begin
          parity_out <= parity_acc ^ ser_in;
        end
      end else if (start_in) begin
        parity_acc <= 1'b0;
      end
    end
  end
`else
  logic unused_last_bit;
  assign unused_last_bit = last_bit;
`endif

endmodule

// File: tb/tb_shreg_univ_al_seq.sv
// Self-checking bench for shreg_univ_al_seq: MSB-first and LSB-first instances share stimulus.
// Build with SHREG_UNIV_PARITY_EN defined to also cover parity_out.
module tb_shreg_univ_al_seq;

  localparam logic [7:0] R0 = 8'h00;
  localparam logic [7:0] R1 = 8'hA5;

  logic       clk;
  logic       reset_al_in;
  logic       en_in;
  logic [2:0] mode_in;
  logic [7:0] d_in;
  logic       ser_in;
  logic       start_in;
  logic [7:0] q0, q1;
  logic       ser0, ser1, busy0, busy1, done0, done1;
`ifdef SHREG_UNIV_PARITY_EN
  logic       par0, par1;
  logic       last_par;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] m_q;

  shreg_univ_al_seq #(.WIDTH(8), .LSB_FIRST(1'b0), .RESET_VAL(R0)) dut0 (
    .clk(clk), .reset_al_in(reset_al_in), .en_in(en_in), .mode_in(mode_in),
    .d_in(d_in), .ser_in(ser_in), .start_in(start_in), .q_out(q0),
    .ser_out(ser0), .busy_out(busy0), .done_out(done0)
`ifdef SHREG_UNIV_PARITY_EN
    , .parity_out(par0)
`endif
  );

  shreg_univ_al_seq #(.WIDTH(8), .LSB_FIRST(1'b1), .RESET_VAL(R1)) dut1 (
    .clk(clk), .reset_al_in(reset_al_in), .en_in(en_in), .mode_in(mode_in),
    .d_in(d_in), .ser_in(ser_in), .start_in(start_in), .q_out(q1),
    .ser_out(ser1), .busy_out(busy1), .done_out(done1)
`ifdef SHREG_UNIV_PARITY_EN
    , .parity_out(par1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Manual-mode reference: plain arithmetic on the 8-bit value.
  function automatic logic [7:0] model_mode(logic [7:0] v, logic [2:0] m, logic [7:0] d, logic s);
    int x;
    x = int'(v);
    case (m)
      3'd1:    x = int'(d);
      3'd2:    x = (x * 2) + int'(s);
      3'd3:    x = (x / 2) + int'(s) * 128;
      3'd4:    x = (x * 2) + (x / 128);
      3'd5:    x = (x / 2) + (x % 2) * 128;
      3'd6:    x = 255;
      3'd7:    x = 0;
      default: x = int'(v);
    endcase
    return 8'(x & 255);
  endfunction

  function automatic logic [7:0] bitrev(logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // Expected register contents after k serializer shifts of word while receiving rx (first bit = rx[7]).
  function automatic logic [7:0] exp_q0(logic [7:0] word, logic [7:0] rx, int k);
    return 8'(((int'(word) << k) | (int'(rx) >> (8 - k))) & 255);
  endfunction

  function automatic logic [7:0] exp_q1(logic [7:0] word, logic [7:0] rx, int k);
    int rv;
    rv = int'(bitrev(rx));
    return 8'(((int'(word) >> k) | ((rv & ((1 << k) - 1)) << (8 - k))) & 255);
  endfunction

  task automatic apply_stimulus(input logic en, input logic [2:0] mode, input logic [7:0] d, input logic s);
    en_in   = en;
    mode_in = mode;
    d_in    = d;
    ser_in  = s;
    start_in = 1'b0;
    tick();
    if (en) m_q = model_mode(m_q, mode, d, s);
    check_output("manual_q0", 32'(q0), 32'(m_q));
    check_output("manual_q1", 32'(q1), 32'(m_q));
    check_output("manual_ser0", 32'(ser0), 32'(m_q[7]));
    check_output("manual_ser1", 32'(ser1), 32'(m_q[0]));
    check_output("manual_busy", 32'(busy0 | busy1), 32'(0));
  endtask

  task automatic start_transfer(input logic [7:0] word);
    d_in     = word;
    start_in = 1'b1;
    en_in    = 1'b1;
    mode_in  = 3'($urandom_range(7));
    ser_in   = 1'($urandom_range(1));
    tick();
    start_in = 1'b0;
    check_output("start_q0", 32'(q0), 32'(word));
    check_output("start_q1", 32'(q1), 32'(word));
    check_output("start_busy", 32'({busy0, busy1}), 32'(2'b11));
    check_output("start_done", 32'({done0, done1}), 32'(2'b00));
  endtask

  task automatic run_busy(input logic [7:0] word, input logic [7:0] rx, input int stall_at, input int stall_len);
    int busy_seen;
    busy_seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          busy_seen += int'(busy0);
          en_in    = 1'b0;
          start_in = 1'($urandom_range(1));
          mode_in  = 3'($urandom_range(7));
          ser_in   = 1'($urandom_range(1));
          tick();
          check_output("stall_q0", 32'(q0), 32'(exp_q0(word, rx, k)));
          check_output("stall_q1", 32'(q1), 32'(exp_q1(word, rx, k)));
          check_output("stall_busy", 32'({busy0, busy1}), 32'(2'b11));
          check_output("stall_done", 32'({done0, done1}), 32'(2'b00));
        end
      end
      check_output("ser_bit0", 32'(ser0), 32'(word[7-k]));
      check_output("ser_bit1", 32'(ser1), 32'(word[k]));
      check_output("busy_q0", 32'(q0), 32'(exp_q0(word, rx, k)));
      check_output("busy_q1", 32'(q1), 32'(exp_q1(word, rx, k)));
      check_output("busy_done", 32'({done0, done1}), 32'(2'b00));
      busy_seen += int'(busy0);
      en_in    = 1'b1;
      ser_in   = rx[7-k];
      start_in = 1'($urandom_range(1));
      mode_in  = 3'($urandom_range(7));
      d_in     = 8'($urandom_range(255));
      tick();
    end
    start_in = 1'b0;
    check_output("final_q0", 32'(q0), 32'(rx));
    check_output("final_q1", 32'(q1), 32'(bitrev(rx)));
    check_output("final_busy", 32'({busy0, busy1}), 32'(2'b00));
    check_output("final_done", 32'({done0, done1}), 32'(2'b11));
    check_output("busy_cycles", 32'(busy_seen), 32'(8 + stall_len));
`ifdef SHREG_UNIV_PARITY_EN
    last_par = ^rx;
    check_output("parity0", 32'(par0), 32'(last_par));
    check_output("parity1", 32'(par1), 32'(last_par));
`endif
  endtask

  task automatic end_idle(input logic [7:0] rx, input logic stall_first);
    start_in = 1'b0;
    mode_in  = 3'd0;
    en_in    = ~stall_first;
    tick();
    en_in = 1'b1;
    tick();
    check_output("idle_done", 32'({done0, done1}), 32'(2'b00));
    check_output("idle_busy", 32'({busy0, busy1}), 32'(2'b00));
    check_output("idle_q0", 32'(q0), 32'(rx));
    check_output("idle_q1", 32'(q1), 32'(bitrev(rx)));
`ifdef SHREG_UNIV_PARITY_EN
    check_output("parity_hold", 32'(par0), 32'(last_par));
`endif
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] rx;
    reset_al_in = 1'b0;
    en_in = 1'b1; mode_in = 3'd0; d_in = 8'h00; ser_in = 1'b0; start_in = 1'b0;
    m_q = 8'h00;
    tick();
    tick();
    check_output("reset_q0", 32'(q0), 32'(R0));
    check_output("reset_q1", 32'(q1), 32'(R1));
    check_output("reset_ser1", 32'(ser1), 32'(R1[0]));
    check_output("reset_busy", 32'({busy0, busy1}), 32'(2'b00));
    check_output("reset_done", 32'({done0, done1}), 32'(2'b00));
    reset_al_in = 1'b1;

    $display("[TB] manual modes");
    apply_stimulus(1'b1, 3'd1, 8'h81, 1'b0);
    apply_stimulus(1'b1, 3'd4, 8'h00, 1'b0);
    check_output("rotl_81", 32'(q0), 32'h03);
    apply_stimulus(1'b1, 3'd1, 8'h81, 1'b0);
    apply_stimulus(1'b1, 3'd3, 8'h00, 1'b1);
    check_output("shr_81", 32'(q0), 32'hC0);
    apply_stimulus(1'b1, 3'd6, 8'h00, 1'b0);
    check_output("set_all", 32'(q0), 32'hFF);
    apply_stimulus(1'b1, 3'd7, 8'h00, 1'b1);
    check_output("clr_all", 32'(q0), 32'h00);
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(1'($urandom_range(3) != 0), 3'($urandom_range(7)),
                     8'($urandom_range(255)), 1'($urandom_range(1)));
    end

    $display("[TB] serializer with stall and back-to-back");
    apply_stimulus(1'b1, 3'd7, 8'h00, 1'b0);
    start_transfer(8'hA5);
    run_busy(8'hA5, 8'h3C, 4, 3);
    start_transfer(8'h0F);
    rx = 8'($urandom_range(255));
    run_busy(8'h0F, rx, -1, 0);
    end_idle(rx, 1'b1);

    $display("[TB] parity and random transfers");
    w = 8'($urandom_range(255));
    start_transfer(w);
    run_busy(w, 8'h3D, -1, 0);
    end_idle(8'h3D, 1'b0);
    for (int t = 0; t < 5; t++) begin
      w  = 8'($urandom_range(255));
      rx = 8'($urandom_range(255));
      start_transfer(w);
      run_busy(w, rx, int'($urandom_range(7)), int'($urandom_range(3)));
      end_idle(rx, 1'($urandom_range(1)));
    end

    $display("[TB] reset mid-transfer");
    w = 8'($urandom_range(255));
    start_transfer(w);
    for (int k = 0; k < 3; k++) begin
      ser_in = 1'($urandom_range(1));
      tick();
    end
    #2 reset_al_in = 1'b0;
    #1;
    check_output("abort_q0", 32'(q0), 32'(R0));
    check_output("abort_q1", 32'(q1), 32'(R1));
    check_output("abort_busy", 32'({busy0, busy1}), 32'(2'b00));
    check_output("abort_done", 32'({done0, done1}), 32'(2'b00));
    #3 reset_al_in = 1'b1;
    mode_in = 3'd0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_output("post_abort_done", 32'({done0, done1}), 32'(2'b00));
      check_output("post_abort_busy", 32'({busy0, busy1}), 32'(2'b00));
      check_output("post_abort_q0", 32'(q0), 32'(R0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
